// File: rtl/gcd_operand_capture.sv
// Front end for the GCD datapath: button sync/debounce, operand capture on "go",
// zero-operand rejection, one-cycle start pulse and lockout until the core reports done.
module gcd_operand_capture #(
    parameter int DATA_W          = 8,
    parameter int DEBOUNCE_CYCLES = 4,
    parameter int CNT_W           = 20
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic [3:0]        BTN,
    input  logic [DATA_W-1:0] SW,
    input  logic [DATA_W-1:0] DIP,
    input  logic              gcd_done,
    output logic [DATA_W-1:0] op_a,
    output logic [DATA_W-1:0] op_b,
    output logic              start,
    output logic              busy,
    output logic              err,
    output logic [3:0]        btn_level
);

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_LOAD  = 2'd1,
        S_START = 2'd2,
        S_WAIT  = 2'd3
    } state_t;

    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DEBOUNCE_CYCLES - 1);

    logic [3:0]        sync1_reg;
    logic [3:0]        sync2_reg;
    logic [3:0]        btn_level_reg;
    logic [3:0]        btn_level_q_reg;
    logic [3:0]        press;
    state_t            state_reg;
    logic [DATA_W-1:0] op_a_reg;
    logic [DATA_W-1:0] op_b_reg;
    logic              start_reg;
    logic              busy_reg;
    logic              err_reg;

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            sync1_reg <= '0;
            sync2_reg <= '0;
        end else begin
            sync1_reg <= BTN;
            sync2_reg <= sync1_reg;
        end
    end

    // Each bit has its own counter; the level only moves after the synchronized
    // input has disagreed with it for DEBOUNCE_CYCLES consecutive edges.
    generate
        for (genvar gi = 0; gi < 4; gi++) begin : gen_db
            logic [CNT_W-1:0] cnt_reg;
            logic             lvl_reg;

            always_ff @(posedge clk) begin
                if (!rst_n) begin
                    cnt_reg <= '0;
                    lvl_reg <= 1'b0;
                end else if (sync2_reg[gi] != lvl_reg) begin
                    if (cnt_reg == CNT_LAST) begin
                        cnt_reg <= '0;
                        lvl_reg <= ~lvl_reg;
                    end else begin
                        cnt_reg <= cnt_reg + 1'b1;
                    end
                end else begin
                    cnt_reg <= '0;
                end
            end

            assign btn_level_reg[gi] = lvl_reg;
        end
    endgenerate

    assign press = btn_level_reg & ~btn_level_q_reg;

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            btn_level_q_reg <= '0;
            state_reg       <= S_IDLE;
            op_a_reg        <= '0;
            op_b_reg        <= '0;
            start_reg       <= 1'b0;
            busy_reg        <= 1'b0;
            err_reg         <= 1'b0;
        end else begin
            btn_level_q_reg <= btn_level_reg;
            start_reg       <= 1'b0;
            if (press[3]) begin
                // Clear wins over a simultaneous go or done.
                state_reg <= S_IDLE;
                busy_reg  <= 1'b0;
                op_a_reg  <= '0;
                op_b_reg  <= '0;
                err_reg   <= 1'b0;
            end else begin
                case (state_reg)
                    S_IDLE: begin
                        if (press[0]) begin
                            op_a_reg  <= SW;
                            op_b_reg  <= DIP;
                            err_reg   <= 1'b0;
                            state_reg <= S_LOAD;
                            busy_reg  <= 1'b1;
                        end
                    end
                    S_LOAD: begin
                        if (op_a_reg == '0 || op_b_reg == '0) begin
                            err_reg   <= 1'b1;
                            state_reg <= S_IDLE;
                            busy_reg  <= 1'b0;
                        end else begin
                            start_reg <= 1'b1;
                            state_reg <= S_START;
                        end
                    end
                    S_START: begin
                        state_reg <= S_WAIT;
                    end
                    S_WAIT: begin
                        if (gcd_done) begin
                            state_reg <= S_IDLE;
                            busy_reg  <= 1'b0;
                        end
                    end
                    default: begin
                        state_reg <= S_IDLE;
                        busy_reg  <= 1'b0;
                    end
                endcase
            end
        end
    end

    assign op_a      = op_a_reg;
    assign op_b      = op_b_reg;
    assign start     = start_reg;
    assign busy      = busy_reg;
    assign err       = err_reg;
    assign btn_level = btn_level_reg;

endmodule

// File: tb/tb_gcd_operand_capture.sv
// Scoreboard bench for gcd_operand_capture: stimulus queues expected start events,
// a monitor pops and checks them whenever the DUT pulses start.
module tb_gcd_operand_capture;

    localparam int DW = 8;

    logic          clk = 1'b0;
    logic          rst_n;
    logic [3:0]    BTN;
    logic [DW-1:0] SW;
    logic [DW-1:0] DIP;
    logic          gcd_done;
    logic [DW-1:0] op_a;
    logic [DW-1:0] op_b;
    logic          start;
    logic          busy;
    logic          err;
    logic [3:0]    btn_level;

    gcd_operand_capture #(.DATA_W(DW), .DEBOUNCE_CYCLES(4), .CNT_W(20)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .BTN       (BTN),
        .SW        (SW),
        .DIP       (DIP),
        .gcd_done  (gcd_done),
        .op_a      (op_a),
        .op_b      (op_b),
        .start     (start),
        .busy      (busy),
        .err       (err),
        .btn_level (btn_level)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [DW-1:0] a;
        logic [DW-1:0] b;
        int            cyc;
    } exp_t;

    exp_t sbq[$];
    int   cyc = 0;
    int   checks = 0;
    int   errors = 0;

    // Abstract model of what the outputs should currently be.
    logic [DW-1:0] exp_a = '0;
    logic [DW-1:0] exp_b = '0;
    logic          exp_err = 1'b0;

    always @(posedge clk) cyc <= cyc + 1;

    function automatic void chk(input string name, input int act, input int exp);
        checks++;
        if (act != exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d (cycle %0d)", name, act, exp, cyc);
        end else begin
            $display("ok   %s = %0d (cycle %0d)", name, act, cyc);
        end
    endfunction

    // Monitor: every start pulse must match the oldest queued expectation.
    bit prev_start = 1'b0;
    always @(negedge clk) begin
        if (start) begin
            exp_t e;
            if (prev_start) chk("start_width", 2, 1);
            if (sbq.size() == 0) begin
                chk("unexpected_start", 1, 0);
            end else begin
                e = sbq.pop_front();
                chk("start_op_a", int'(op_a), int'(e.a));
                chk("start_op_b", int'(op_b), int'(e.b));
                chk("start_cycle", cyc, e.cyc);
            end
        end
        prev_start = start;
    end

    task automatic tick(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic chk_model(input string tag);
        chk({tag, "_op_a"}, int'(op_a), int'(exp_a));
        chk({tag, "_op_b"}, int'(op_b), int'(exp_b));
        chk({tag, "_err"}, int'(err), int'(exp_err));
    endtask

    // A clean go press issued from IDLE; returns in WAIT (or IDLE for a zero operand).
    task automatic press0(input logic [DW-1:0] a, input logic [DW-1:0] b, input bit done_in_start);
        exp_t e;
        bit   ok;
        ok  = (a != 0) && (b != 0);
        SW  = a;
        DIP = b;
        BTN[0] = 1'b1;
        if (ok) begin
            e.a = a; e.b = b; e.cyc = cyc + 8;
            sbq.push_back(e);
        end
        exp_a = a; exp_b = b; exp_err = 1'b0;
        tick(7);
        chk_model("capture");
        chk("capture_busy", int'(busy), 1);
        tick(1);
        BTN[0] = 1'b0;
        if (!ok) begin
            exp_err = 1'b1;
            chk("zero_err", int'(err), 1);
            chk("zero_busy", int'(busy), 0);
            tick(8);
        end else if (done_in_start) begin
            gcd_done = 1'b1;
            tick(1);
            gcd_done = 1'b0;
            chk("done_in_start_busy", int'(busy), 1);
            tick(7);
        end else begin
            tick(8);
        end
        if (ok) chk("wait_busy", int'(busy), 1);
    endtask

    task automatic raw_pulse(input int idx, input int hold);
        BTN[idx] = 1'b1;
        tick(hold);
        BTN[idx] = 1'b0;
        tick(8);
    endtask

    task automatic done_pulse();
        gcd_done = 1'b1;
        tick(1);
        gcd_done = 1'b0;
        chk("done_busy", int'(busy), 0);
    endtask

    task automatic do_clear();
        SW = 8'hA5;
        DIP = 8'h5A;
        raw_pulse(3, 8);
        exp_a = '0; exp_b = '0; exp_err = 1'b0;
        chk("clear_busy", int'(busy), 0);
        chk_model("clear");
    endtask

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [DW-1:0] a, b;
        int mode;

        rst_n = 1'b0; BTN = 4'hF; SW = '0; DIP = '0; gcd_done = 1'b0;
        tick(3);
        chk("rst_op_a", int'(op_a), 0);
        chk("rst_op_b", int'(op_b), 0);
        chk("rst_start", int'(start), 0);
        chk("rst_busy", int'(busy), 0);
        chk("rst_err", int'(err), 0);
        chk("rst_btn_level", int'(btn_level), 0);
        rst_n = 1'b1;
        tick(5);
        chk("btn_level_pre", int'(btn_level), 0);
        tick(1);
        chk("btn_level_post", int'(btn_level), 15);
        tick(2);
        chk("post_rst_busy", int'(busy), 0);
        BTN = 4'h0;
        tick(8);
        chk("btn_released", int'(btn_level), 0);

        // Nominal
        press0(8'd10, 8'd5, 1'b0);
        tick(3);
        done_pulse();
        chk_model("nominal_done");

        // Bounce on go: runs of 2 are shorter than the debounce window
        for (int i = 0; i < 6; i++) begin
            BTN[0] = ~BTN[0];
            tick(2);
            chk("bounce_level0", int'(btn_level[0]), 0);
            chk("bounce_busy", int'(busy), 0);
        end
        BTN[0] = 1'b0;
        tick(8);

        // Zero operand then a valid capture
        press0(8'd0, 8'd5, 1'b0);
        press0(8'd12, 8'd18, 1'b0);
        done_pulse();

        // Lockout during WAIT, done in START ignored, done in IDLE ignored
        press0(8'd33, 8'd77, 1'b1);
        SW = 8'd1; DIP = 8'd2;
        raw_pulse(0, 8);
        chk_model("lockout");
        done_pulse();
        done_pulse();

        // Clear during WAIT
        press0(8'd9, 8'd6, 1'b0);
        do_clear();

        // Go and clear together in IDLE: clear wins, nothing captured
        press0(8'd40, 8'd4, 1'b0);
        done_pulse();
        SW = 8'd99; DIP = 8'd98;
        BTN = 4'b1001;
        tick(8);
        BTN = 4'b0000;
        tick(8);
        exp_a = '0; exp_b = '0; exp_err = 1'b0;
        chk("simul_busy", int'(busy), 0);
        chk_model("simul");

        // Reset while in LOAD aborts without a start
        SW = 8'd3; DIP = 8'd4; BTN[0] = 1'b1;
        tick(7);
        rst_n = 1'b0; BTN = 4'h0;
        tick(2);
        chk("midrst_busy", int'(busy), 0);
        chk("midrst_op_a", int'(op_a), 0);
        chk("midrst_start", int'(start), 0);
        rst_n = 1'b1;
        exp_a = '0; exp_b = '0; exp_err = 1'b0;
        tick(12);
        chk("midrst_after_busy", int'(busy), 0);

        // Randomized transactions
        for (int i = 0; i < 24; i++) begin
            a = DW'($urandom_range(1, 255));
            b = DW'($urandom_range(1, 255));
            if ($urandom_range(0, 5) == 0) a = '0;
            if ($urandom_range(0, 5) == 0) b = '0;
            press0(a, b, $urandom_range(0, 3) == 0);
            if (a == 0 || b == 0) continue;
            mode = $urandom_range(0, 2);
            case (mode)
                0: begin
                    SW = ~a; DIP = ~b;
                    raw_pulse(0, 8);
                    chk_model("rand_lockout");
                    tick($urandom_range(0, 5));
                    done_pulse();
                end
                1: do_clear();
                default: begin
                    tick($urandom_range(0, 10));
                    done_pulse();
                    tick($urandom_range(1, 4));
                    done_pulse();
                    chk_model("rand_done");
                end
            endcase
        end

        tick(4);
        chk("scoreboard_empty", sbq.size(), 0);
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
